// File: rtl/uart_mmio_bridge_pkg.sv
// uart_mmio_bridge_pkg: register select, STATUS bit positions, TX FSM encoding
// and the transmitter busy timeout shared by the bridge files.
package uart_mmio_bridge_pkg;
  localparam logic REG_DATA = 1'b0;
  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_RX_OVF = 2;
  localparam int BUSY_TIMEOUT = 4;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE} tx_state_t;
endpackage

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with wrap-bit pointers; pop on empty is ignored,
// and a push into a full FIFO succeeds only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU-mapped UART port with TX/RX FIFOs, transmitter handshake and RX irq.
// Optional hardware echo of received bytes into the TX FIFO under `UART_LOOPBACK_EN.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int   FIFO_AW   = 4,
  parameter logic DATA_OFFS = REG_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        irq_o
);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  logic rd_data, wr_data, rd_status;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_dout, tx_dout, tx_din;
  logic tx_push, tx_pop, rx_ovf, ovf_set;
  logic [2:0] status;
  tx_state_t state;
  logic [CW-1:0] wait_cnt;
  assign rd_data = ce_i && !we_i && addr_i == DATA_OFFS;
  assign wr_data = ce_i && we_i && addr_i == DATA_OFFS;
  assign rd_status = ce_i && !we_i && addr_i != DATA_OFFS;
  // A full RX FIFO still accepts the byte when the CPU pops in the same cycle.
  assign ovf_set = rx_ready_i && rx_full && !rd_data;
  assign tx_pop = state == IDLE && !tx_empty && !tx_busy_i;
`ifdef UART_LOOPBACK_EN
  assign tx_push = wr_data || (rx_ready_i && !ovf_set);
  assign tx_din = wr_data ? wdata_i : rx_data_i;
`else
  assign tx_push = wr_data;
  assign tx_din = wdata_i;
`endif
  always_comb begin
    status = '0;
    status[ST_TX_READY] = !tx_full;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_RX_OVF] = rx_ovf;
  end
  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx (
    .clk(clk), .rst(rst), .push(rx_ready_i), .pop(rd_data), .din(rx_data_i),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(tx_din),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rdata_o <= '0;
      ack_o <= 1'b0;
      irq_o <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      ack_o <= ce_i;
      irq_o <= !rx_empty;
      rx_ovf <= ovf_set || (rx_ovf && !rd_status);
      if (rd_data) rdata_o <= {24'b0, rx_empty ? 8'h00 : rx_dout};
      else if (rd_status) rdata_o <= {29'b0, status};
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tx_start_o <= 1'b0;
      tx_data_o <= '0;
      wait_cnt <= '0;
    end else begin
      tx_start_o <= 1'b0;
      case (state)
        IDLE: if (tx_pop) begin
          tx_data_o <= tx_dout;
          tx_start_o <= 1'b1;
          state <= START;
        end
        START: begin
          wait_cnt <= '0;
          state <= WAIT_BUSY;
        end
        // Fall through after the timeout in case the transmitter finished unseen.
        WAIT_BUSY: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (tx_busy_i || wait_cnt == CW'(BUSY_TIMEOUT - 1)) state <= WAIT_IDLE;
        end
        WAIT_IDLE: if (!tx_busy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: randomized scenarios against a queue-based model of the
// register map, FIFOs and transmitter; a behavioural transmitter records every start.
module tb_uart_mmio_bridge;
  localparam logic A_DATA = 1'b0;
  localparam logic A_STAT = 1'b1;
  logic clk, rst, ce, we, addr, tx_start, tx_busy, rx_ready, ack, irq;
  logic [7:0] wdata, tx_data, rx_data;
  logic [31:0] rdata, smask;
  int tests = 0, fails = 0;
  int busy_len = 10, busy_left = 0, start_in_busy = 0;
  bit hold = 0, silent = 0;
  logic [7:0] got[$];
  logic [7:0] m_rx[$];

  uart_mmio_bridge dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .ack_o(ack), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .tx_busy_i(tx_busy), .rx_ready_i(rx_ready), .rx_data_i(rx_data), .irq_o(irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: records each started byte, then stays busy for busy_len cycles.
  initial begin
    tx_busy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) busy_left--;
      if (tx_start === 1'b1) begin
        if (tx_busy) start_in_busy++;
        got.push_back(tx_data);
        if (!silent) busy_left = busy_len;
      end
      tx_busy = hold || busy_left > 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic w, input logic a, input logic [7:0] d, output logic [31:0] r);
    ce = 1; we = w; addr = a; wdata = d;
    tick(1);
    ce = 0; we = 0;
    r = rdata;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_ready = 1; rx_data = b;
    tick(1);
    rx_ready = 0;
  endtask

  task automatic drain();
    hold = 0; silent = 0;
    tick(400);
    got.delete();
    start_in_busy = 0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 3000 && got.size() < n; i++) tick(1);
    tick(40);
  endtask

  task automatic test_reset();
    tick(2);
    tests++;
    if ({rdata, ack, tx_start, tx_data, irq} !== 43'd0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {rdata, ack, tx_start, tx_data, irq});
    end
    rst = 1;
    tick(2);
  endtask

  task automatic test_bus_timing();
    logic [31:0] r;
    ce = 1; we = 0; addr = A_STAT;
    tick(1);
    ce = 0;
    tests++;
    if (ack !== 1'b1 || rdata !== 32'h1) begin
      fails++; $display("FAIL status_ack: ack %b rdata %h required 1 / 1", ack, rdata);
    end
    tick(1);
    tests++;
    if (ack !== 1'b0) begin fails++; $display("FAIL ack_pulse: got %b required 0", ack); end
    ce = 1; we = 0; addr = A_STAT;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      tests++;
      if (ack !== 1'b1) begin fails++; $display("FAIL b2b_ack%0d: got %b required 1", i, ack); end
    end
    ce = 0;
    tick(1);
    tests++;
    if (ack !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b required 0", ack); end
    bus(1, A_STAT, 8'hFF, r);
    tests++;
    if (ack !== 1'b1 || r !== 32'h1) begin
      fails++; $display("FAIL status_write_hold: ack %b rdata %h required 1 / 1", ack, r);
    end
  endtask

  task automatic test_tx_order();
    logic [31:0] r;
    drain();
    busy_len = 10;
    bus(1, A_DATA, 8'h41, r);
    bus(1, A_DATA, 8'h42, r);
    wait_tx(2);
    tests++;
    if (got.size() != 2 || got[0] !== 8'h41 || got[1] !== 8'h42) begin
      fails++; $display("FAIL tx_order: got %0d bytes %p required 41 42", got.size(), got);
    end
    tests++;
    if (start_in_busy != 0) begin fails++; $display("FAIL tx_start_busy: got %0d required 0", start_in_busy); end
  endtask

  task automatic test_tx_full();
    logic [31:0] r;
    drain();
    hold = 1;
    tick(2);
    for (int i = 0; i < 16; i++) bus(1, A_DATA, 8'(i), r);
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL tx_full_status: got %h required 0", r); end
    bus(1, A_DATA, 8'h10, r);
    tests++;
    if (ack !== 1'b1) begin fails++; $display("FAIL tx_full_ack: got %b required 1", ack); end
    busy_len = 3;
    hold = 0;
    wait_tx(16);
    tests++;
    if (got.size() != 16) begin fails++; $display("FAIL tx_full_count: got %0d required 16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== 8'(i)) begin fails++; $display("FAIL tx_full_byte%0d: got %h required %h", i, got[i], 8'(i)); end
    end
  endtask

  task automatic test_tx_random();
    logic [31:0] r;
    logic [7:0] exp[$];
    int n;
    for (int k = 0; k < 3; k++) begin
      drain();
      exp.delete();
      silent = (k == 0);
      busy_len = $urandom_range(1, 8);
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        exp.push_back(8'($urandom));
        bus(1, A_DATA, exp[i], r);
        if ($urandom_range(0, 1) == 1) tick(1);
      end
      wait_tx(n);
      tests++;
      if (got != exp) begin fails++; $display("FAIL tx_random%0d: got %p required %p", k, got, exp); end
      tests++;
      if (start_in_busy != 0) begin fails++; $display("FAIL tx_random_busy%0d: got %0d required 0", k, start_in_busy); end
    end
  endtask

  task automatic test_rx_basic();
    logic [31:0] r;
    rx_push(8'h55);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_lag: got %b required 0", irq); end
    tick(1);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b required 1", irq); end
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if ((r & smask) !== (32'h3 & smask)) begin fails++; $display("FAIL rx_status: got %h required 3", r); end
    bus(0, A_DATA, 8'h00, r);
    tests++;
    if (r !== 32'h55) begin fails++; $display("FAIL rx_data: got %h required 55", r); end
    tick(1);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b required 0", irq); end
    bus(0, A_DATA, 8'h00, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL rx_empty_read: got %h required 0", r); end
    rx_ready = 1; rx_data = 8'h5A;
    bus(0, A_DATA, 8'h00, r);
    rx_ready = 0;
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL rx_pushpop_empty: got %h required 0", r); end
    bus(0, A_DATA, 8'h00, r);
    tests++;
    if (r !== 32'h5A) begin fails++; $display("FAIL rx_pushpop_kept: got %h required 5a", r); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] r;
    logic [7:0] b;
    bit ovf;
    int n;
    m_rx.delete();
    ovf = 0;
    n = $urandom_range(17, 20);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (m_rx.size() < 16) m_rx.push_back(b);
      else ovf = 1;
      rx_push(b);
    end
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if ((r & smask) !== ({29'b0, ovf, 1'b1, 1'b1} & smask)) begin fails++; $display("FAIL ovf_status: got %h required %h", r, {29'b0, ovf, 2'b11}); end
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if ((r & smask) !== (32'h3 & smask)) begin fails++; $display("FAIL ovf_cleared: got %h required 3", r); end
    // Full FIFO: push with a same-cycle pop is accepted without overflow.
    b = 8'($urandom);
    rx_ready = 1; rx_data = b;
    bus(0, A_DATA, 8'h00, r);
    rx_ready = 0;
    tests++;
    if (r !== {24'b0, m_rx[0]}) begin fails++; $display("FAIL full_pushpop: got %h required %h", r, m_rx[0]); end
    void'(m_rx.pop_front());
    m_rx.push_back(b);
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if ((r & smask) !== (32'h3 & smask)) begin fails++; $display("FAIL full_pushpop_ovf: got %h required 3", r); end
    // Overflow arriving alongside a STATUS read survives the clear.
    rx_ready = 1; rx_data = 8'($urandom);
    bus(0, A_STAT, 8'h00, r);
    rx_ready = 0;
    tests++;
    if ((r & smask) !== (32'h3 & smask)) begin fails++; $display("FAIL ovf_race_read: got %h required 3", r); end
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if ((r & smask) !== (32'h7 & smask)) begin fails++; $display("FAIL ovf_race_wins: got %h required 7", r); end
    for (int i = 0; i < 16; i++) begin
      bus(0, A_DATA, 8'h00, r);
      tests++;
      if (r !== {24'b0, m_rx[0]}) begin fails++; $display("FAIL rx_drain%0d: got %h required %h", i, r, m_rx[0]); end
      void'(m_rx.pop_front());
    end
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if ((r & smask) !== (32'h1 & smask)) begin fails++; $display("FAIL rx_drained_status: got %h required 1", r); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] r;
    drain();
    busy_len = 1000;
    for (int i = 0; i < 4; i++) bus(1, A_DATA, 8'hA0 + 8'(i), r);
    tick(10);
    tests++;
    if (got.size() != 1) begin fails++; $display("FAIL mid_tx_inflight: got %0d required 1", got.size()); end
    rx_push(8'h77);
    bus(0, A_STAT, 8'h00, r);
    tick(2);
    #2 rst = 0;
    #1;
    tests++;
    if ({rdata, ack, tx_start, tx_data, irq} !== 43'd0) begin
      fails++; $display("FAIL async_reset: got %h required 0", {rdata, ack, tx_start, tx_data, irq});
    end
    @(posedge clk);
    #1;
    tick(1);
    rst = 1;
    tick(20);
    tests++;
    if (got.size() != 1) begin fails++; $display("FAIL reset_no_start: got %0d required 1", got.size()); end
    bus(0, A_STAT, 8'h00, r);
    tests++;
    if (r !== 32'h1) begin fails++; $display("FAIL reset_status: got %h required 1", r); end
    busy_left = 0;
    tick(40);
    tests++;
    if (got.size() != 1) begin fails++; $display("FAIL reset_flushed: got %0d required 1", got.size()); end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [31:0] r;
    drain();
    busy_len = 5;
    rx_push(8'h61);
    wait_tx(1);
    tests++;
    if (got.size() != 1 || got[0] !== 8'h61) begin fails++; $display("FAIL echo: got %p required 61", got); end
    rx_ready = 1; rx_data = 8'h62;
    bus(1, A_DATA, 8'h63, r);
    rx_ready = 0;
    wait_tx(2);
    tests++;
    if (got.size() != 2 || got[1] !== 8'h63) begin fails++; $display("FAIL echo_priority: got %p required 61 63", got); end
    bus(0, A_DATA, 8'h00, r);
    tests++;
    if (r !== 32'h61) begin fails++; $display("FAIL echo_rx0: got %h required 61", r); end
    bus(0, A_DATA, 8'h00, r);
    tests++;
    if (r !== 32'h62) begin fails++; $display("FAIL echo_rx1: got %h required 62", r); end
  endtask
`endif

  initial begin
    rst = 0; ce = 0; we = 0; addr = 0; wdata = 0; rx_ready = 0; rx_data = 0;
`ifdef UART_LOOPBACK_EN
    smask = 32'h6;
`else
    smask = 32'h7;
`endif
    test_reset();
    test_bus_timing();
    test_tx_order();
    test_tx_full();
    test_tx_random();
    drain();
    test_rx_basic();
    drain();
    test_rx_overflow();
    test_reset_mid_tx();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
